tff_bank_counter: RTL and testbench

- Parametrised successor to the stdlib single toggle flip-flop.
- A WIDTH-bit register that runs in one of four modes:
  - a per-bit toggle bank;
  - a modulo up counter;
  - a modulo down counter;
  - a parallel loader.
- Adds terminal-count and registered wrap indications.
- Stdlib building block for dividers, sequencers and event counters.

---
 rtl/tff_bank_counter_if.sv | 26 ++
 rtl/tff_bank_counter.sv | 101 ++++++++++
 tb/tb_tff_bank_counter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tff_bank_counter_if.sv
// rtl/tff_bank_counter_if.sv - control and status bundle for the toggle-bank / modulo counter
interface tff_bank_counter_if #(
    parameter int WIDTH = 8
);
    logic             _E;
    logic [1:0]       _mode;
    logic [WIDTH-1:0] _T;
    logic [WIDTH-1:0] _D;
    logic [WIDTH-1:0] _Q;
    logic [WIDTH-1:0] _QNOT;
    logic             _tc;
    logic             _wrap;
    logic [WIDTH-1:0] _return;

    // Side that issues enable/mode/mask/data and observes the register.
    modport master (
        output _E, _mode, _T, _D,
        input  _Q, _QNOT, _tc, _wrap, _return
    );

    // Side that owns the register.
    modport slave (
        input  _E, _mode, _T, _D,
        output _Q, _QNOT, _tc, _wrap, _return
    );
endinterface

// File: rtl/tff_bank_counter.sv
// rtl/tff_bank_counter.sv - WIDTH-bit toggle bank / modulo up-down counter / loader; TFF_SATURATE_EN pins counts at the limits
module tff_bank_counter #(
    parameter int              WIDTH       = 8,
    parameter longint unsigned MODULUS     = 0,
    parameter longint unsigned RESET_VALUE = 0
) (
    input logic               _clock,
    input logic               _reset,
    tff_bank_counter_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_LOAD   = 2'b11
    } mode_e;

    // Largest legal count; MODULUS of zero means the full natural range.
    localparam logic [WIDTH-1:0] MAX_Q   = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_Q  = '0;

    mode_e            mode;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             wrap_q;
    logic             wrap_next;

    assign mode = mode_e'(bus._mode);

    // Any value beyond the modulus is pinned to the last legal count.
    function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
        return (v > MAX_Q) ? MAX_Q : v;
    endfunction

    // Next-state decode: enable gates everything, then the selected mode acts.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (bus._E) begin
            case (mode)
                MODE_TOGGLE: begin
                    q_next = clamp_max(q ^ bus._T);
                end
                MODE_UP: begin
                    // An out-of-range state counts as already sitting at MAX.
                    if (q >= MAX_Q) begin
`ifdef TFF_SATURATE_EN
                        q_next    = MAX_Q;
`else
                        q_next    = ZERO_Q;
                        wrap_next = 1'b1;
`endif
                    end else begin
                        q_next = q + ONE_Q;
                    end
                end
                MODE_DOWN: begin
                    if (q == ZERO_Q) begin
`ifdef TFF_SATURATE_EN
                        q_next    = ZERO_Q;
`else
                        q_next    = MAX_Q;
                        wrap_next = 1'b1;
`endif
                    end else begin
                        q_next = q - ONE_Q;
                    end
                end
                MODE_LOAD: begin
                    q_next = clamp_max(bus._D);
                end
            endcase
        end
    end

    // State and wrap pulse registers; reset forces them regardless of the clock.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            q      <= RESET_Q;
            wrap_q <= 1'b0;
        end else begin
            q      <= q_next;
            wrap_q <= wrap_next;
        end
    end

    // Terminal count flags the state from which the next enabled edge wraps (or pins).
    always_comb begin
        bus._tc = bus._E & (((mode == MODE_UP) & (q == MAX_Q)) |
                            ((mode == MODE_DOWN) & (q == ZERO_Q)));
    end

    assign bus._Q      = q;
    assign bus._QNOT   = ~q;
    assign bus._return = q;
    assign bus._wrap   = wrap_q;

endmodule

// File: tb/tb_tff_bank_counter.sv
// tb/tb_tff_bank_counter.sv - self-checking bench for tff_bank_counter across three configurations
module tb_tff_bank_counter;

`ifdef TFF_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // a: WIDTH=4 MODULUS=10, b: WIDTH=8 MODULUS=0, c: WIDTH=4 MODULUS=0
    tff_bank_counter_if #(.WIDTH(4)) ia ();
    tff_bank_counter_if #(.WIDTH(8)) ib ();
    tff_bank_counter_if #(.WIDTH(4)) ic ();

    tff_bank_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_a (._clock(clk), ._reset(rst_n), .bus(ia));
    tff_bank_counter #(.WIDTH(8), .MODULUS(0),  .RESET_VALUE(0)) u_b (._clock(clk), ._reset(rst_n), .bus(ib));
    tff_bank_counter #(.WIDTH(4), .MODULUS(0),  .RESET_VALUE(0)) u_c (._clock(clk), ._reset(rst_n), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic model_step(inout int q, output bit w, input bit e, input int mode,
                              input int t, input int d, input int max);
        w = 1'b0;
        if (e) begin
            case (mode)
                0: begin
                    q = q ^ t;
                    if (q > max) q = max;
                end
                1: begin
                    if (q >= max) begin
                        q = SAT ? max : 0;
                        w = !SAT;
                    end else q = q + 1;
                end
                2: begin
                    if (q == 0) begin
                        q = SAT ? 0 : max;
                        w = !SAT;
                    end else q = q - 1;
                end
                default: q = (d > max) ? max : d;
            endcase
        end
    endtask

    function automatic bit model_tc(int q, bit e, int mode, int max);
        return e && ((mode == 1 && q == max) || (mode == 2 && q == 0));
    endfunction

    task automatic test_reset();
        ia._E = 1'b1; ia._mode = 2'b10;
        #1;
        checks++; if (ia._Q !== 4'd0) begin errors++; $display("FAIL reset_q got=%0h exp=0", ia._Q); end
        checks++; if (ia._wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%0b exp=0", ia._wrap); end
        checks++; if (ia._QNOT !== 4'hF) begin errors++; $display("FAIL reset_qnot got=%0h exp=f", ia._QNOT); end
        checks++; if (ia._tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down got=%0b exp=1", ia._tc); end
        step();
        rst_n = 1'b1;
        ia._mode = 2'b01;
        for (int i = 0; i < 6; i++) step();
        checks++; if (ia._Q !== 4'd6) begin errors++; $display("FAIL pre_reset_q got=%0h exp=6", ia._Q); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (ia._Q !== 4'd0) begin errors++; $display("FAIL midreset_q got=%0h exp=0", ia._Q); end
        checks++; if (ia._wrap !== 1'b0) begin errors++; $display("FAIL midreset_wrap got=%0b exp=0", ia._wrap); end
        checks++; if (ia._tc !== 1'b0) begin errors++; $display("FAIL midreset_tc got=%0b exp=0", ia._tc); end
        #1;
        rst_n = 1'b1;
        step();
        checks++; if (ia._Q !== 4'd1) begin errors++; $display("FAIL post_reset_q got=%0h exp=1", ia._Q); end
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_q;
        ia._E = 1'b1; ia._mode = 2'b11; ia._D = 4'd0;
        step();
        ia._mode = 2'b01;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (ia._tc !== (i == 9)) begin errors++; $display("FAIL wrap_up_tc i=%0d got=%0b exp=%0b", i, ia._tc, (i == 9)); end
            step();
            exp_q = (i == 9) ? (SAT ? 4'd9 : 4'd0) : 4'(i + 1);
            checks++; if (ia._Q !== exp_q) begin errors++; $display("FAIL wrap_up_q i=%0d got=%0h exp=%0h", i, ia._Q, exp_q); end
            checks++; if (ia._wrap !== (!SAT && i == 9)) begin errors++; $display("FAIL wrap_up_wrap i=%0d got=%0b exp=%0b", i, ia._wrap, (!SAT && i == 9)); end
        end
        if (!SAT) begin
            checks++; if (ia._QNOT !== 4'hF) begin errors++; $display("FAIL wrap_up_qnot got=%0h exp=f", ia._QNOT); end
        end
        step();
        checks++; if (ia._wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_pulse_len got=%0b exp=0", ia._wrap); end
    endtask

    task automatic test_down_hold();
        logic [3:0] exp_q;
        ia._E = 1'b1; ia._mode = 2'b11; ia._D = 4'd0;
        step();
        ia._mode = 2'b10;
        step();
        exp_q = SAT ? 4'd0 : 4'd9;
        checks++; if (ia._Q !== exp_q) begin errors++; $display("FAIL down_wrap_q got=%0h exp=%0h", ia._Q, exp_q); end
        checks++; if (ia._wrap !== !SAT) begin errors++; $display("FAIL down_wrap_pulse got=%0b exp=%0b", ia._wrap, !SAT); end
        ia._E = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ia._tc !== 1'b0) begin errors++; $display("FAIL hold_tc i=%0d got=%0b exp=0", i, ia._tc); end
            step();
            checks++; if (ia._Q !== exp_q) begin errors++; $display("FAIL hold_q i=%0d got=%0h exp=%0h", i, ia._Q, exp_q); end
            checks++; if (ia._wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap i=%0d got=%0b exp=0", i, ia._wrap); end
        end
    endtask

    task automatic test_toggle();
        ib._E = 1'b1; ib._mode = 2'b11; ib._D = 8'hA5;
        step();
        ib._mode = 2'b00; ib._T = 8'h0F;
        step();
        checks++; if (ib._Q !== 8'hAA) begin errors++; $display("FAIL toggle_0f got=%0h exp=aa", ib._Q); end
        ib._T = 8'h00;
        step();
        checks++; if (ib._Q !== 8'hAA) begin errors++; $display("FAIL toggle_00 got=%0h exp=aa", ib._Q); end
        checks++; if (ib._return !== 8'hAA) begin errors++; $display("FAIL toggle_return got=%0h exp=aa", ib._return); end
        ib._E = 1'b0;
        ia._E = 1'b1; ia._mode = 2'b11; ia._D = 4'h9;
        step();
        ia._mode = 2'b00; ia._T = 4'h6;
        step();
        checks++; if (ia._Q !== 4'h9) begin errors++; $display("FAIL toggle_clamp got=%0h exp=9", ia._Q); end
        ia._T = 4'h1;
        step();
        checks++; if (ia._Q !== 4'h8) begin errors++; $display("FAIL toggle_in_range got=%0h exp=8", ia._Q); end
    endtask

    task automatic test_load_clamp();
        ia._E = 1'b1; ia._mode = 2'b11; ia._D = 4'd7;
        step();
        checks++; if (ia._Q !== 4'd7) begin errors++; $display("FAIL load_7 got=%0h exp=7", ia._Q); end
        ia._D = 4'd12;
        step();
        checks++; if (ia._Q !== 4'd9) begin errors++; $display("FAIL load_12 got=%0h exp=9", ia._Q); end
        ia._mode = 2'b01;
        step();
        checks++; if (ia._Q !== (SAT ? 4'd9 : 4'd0)) begin errors++; $display("FAIL load_then_up got=%0h exp=%0h", ia._Q, (SAT ? 4'd9 : 4'd0)); end
        checks++; if (ia._wrap !== !SAT) begin errors++; $display("FAIL load_then_up_wrap got=%0b exp=%0b", ia._wrap, !SAT); end
        ia._E = 1'b0;
    endtask

    task automatic test_saturate();
        logic [3:0] exp_q [3];
        logic       exp_w [3];
        if (SAT) begin
            exp_q = '{4'd15, 4'd15, 4'd15}; exp_w = '{1'b0, 1'b0, 1'b0};
        end else begin
            exp_q = '{4'd15, 4'd0, 4'd1};   exp_w = '{1'b0, 1'b1, 1'b0};
        end
        ic._E = 1'b1; ic._mode = 2'b11; ic._D = 4'd14;
        step();
        ic._mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ic._Q !== exp_q[i]) begin errors++; $display("FAIL sat_q i=%0d got=%0h exp=%0h", i, ic._Q, exp_q[i]); end
            checks++; if (ic._wrap !== exp_w[i]) begin errors++; $display("FAIL sat_wrap i=%0d got=%0b exp=%0b", i, ic._wrap, exp_w[i]); end
            checks++; if (ic._tc !== (exp_q[i] == 4'd15)) begin errors++; $display("FAIL sat_tc i=%0d got=%0b exp=%0b", i, ic._tc, (exp_q[i] == 4'd15)); end
        end
        ic._E = 1'b0;
    endtask

    task automatic test_random();
        int qa, qb, qc;
        bit wa, wb, wc;
        bit ea, eb, ec;
        int ma, mb, mc, ta, tb, tc, da, db, dc;
        // Start all three from a known reset state.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        qa = 0; qb = 0; qc = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ea = ($urandom_range(0, 7) != 0); ma = $urandom_range(0, 3); ta = $urandom_range(0, 15);  da = $urandom_range(0, 15);
            eb = ($urandom_range(0, 7) != 0); mb = $urandom_range(0, 3); tb = $urandom_range(0, 255); db = $urandom_range(0, 255);
            ec = ($urandom_range(0, 7) != 0); mc = $urandom_range(0, 3); tc = $urandom_range(0, 15);  dc = $urandom_range(0, 15);
            ia._E = ea; ia._mode = 2'(ma); ia._T = 4'(ta); ia._D = 4'(da);
            ib._E = eb; ib._mode = 2'(mb); ib._T = 8'(tb); ib._D = 8'(db);
            ic._E = ec; ic._mode = 2'(mc); ic._T = 4'(tc); ic._D = 4'(dc);
            #1;
            checks++; if (ia._tc !== model_tc(qa, ea, ma, 9))   begin errors++; $display("FAIL rand_tc_a cyc=%0d got=%0b exp=%0b", cyc, ia._tc, model_tc(qa, ea, ma, 9)); end
            checks++; if (ib._tc !== model_tc(qb, eb, mb, 255)) begin errors++; $display("FAIL rand_tc_b cyc=%0d got=%0b exp=%0b", cyc, ib._tc, model_tc(qb, eb, mb, 255)); end
            checks++; if (ic._tc !== model_tc(qc, ec, mc, 15))  begin errors++; $display("FAIL rand_tc_c cyc=%0d got=%0b exp=%0b", cyc, ic._tc, model_tc(qc, ec, mc, 15)); end
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                qa = 0; qb = 0; qc = 0;
                wa = 0; wb = 0; wc = 0;
                rst_n = 1'b1;
            end else begin
                step();
                model_step(qa, wa, ea, ma, ta, da, 9);
                model_step(qb, wb, eb, mb, tb, db, 255);
                model_step(qc, wc, ec, mc, tc, dc, 15);
            end
            checks++; if (ia._Q !== 4'(qa)) begin errors++; $display("FAIL rand_q_a cyc=%0d got=%0h exp=%0h", cyc, ia._Q, qa); end
            checks++; if (ib._Q !== 8'(qb)) begin errors++; $display("FAIL rand_q_b cyc=%0d got=%0h exp=%0h", cyc, ib._Q, qb); end
            checks++; if (ic._Q !== 4'(qc)) begin errors++; $display("FAIL rand_q_c cyc=%0d got=%0h exp=%0h", cyc, ic._Q, qc); end
            checks++; if ({ia._QNOT, ia._return} !== {~4'(qa), 4'(qa)}) begin errors++; $display("FAIL rand_qnot_ret_a cyc=%0d got=%0h/%0h exp=%0h", cyc, ia._QNOT, ia._return, qa); end
            checks++; if ({ib._QNOT, ib._return} !== {~8'(qb), 8'(qb)}) begin errors++; $display("FAIL rand_qnot_ret_b cyc=%0d got=%0h/%0h exp=%0h", cyc, ib._QNOT, ib._return, qb); end
            checks++; if ({ic._QNOT, ic._return} !== {~4'(qc), 4'(qc)}) begin errors++; $display("FAIL rand_qnot_ret_c cyc=%0d got=%0h/%0h exp=%0h", cyc, ic._QNOT, ic._return, qc); end
            checks++; if (ia._wrap !== wa) begin errors++; $display("FAIL rand_wrap_a cyc=%0d got=%0b exp=%0b", cyc, ia._wrap, wa); end
            checks++; if (ib._wrap !== wb) begin errors++; $display("FAIL rand_wrap_b cyc=%0d got=%0b exp=%0b", cyc, ib._wrap, wb); end
            checks++; if (ic._wrap !== wc) begin errors++; $display("FAIL rand_wrap_c cyc=%0d got=%0b exp=%0b", cyc, ic._wrap, wc); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ia._E = 1'b0; ia._mode = 2'b00; ia._T = '0; ia._D = '0;
        ib._E = 1'b0; ib._mode = 2'b00; ib._T = '0; ib._D = '0;
        ic._E = 1'b0; ic._mode = 2'b00; ic._T = '0; ic._D = '0;
        test_reset();
        test_wrap_up();
        test_down_hold();
        test_toggle();
        test_load_clamp();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
